mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares the single memory port between NREQ requester modules, using the same req/done handshake as the memory controller.
- Grants one owner at a time and inserts a one-cycle turnaround between owners.
- Force-releases an owner that holds the memory longer than MAX_HOLD cycles while others are waiting.
- Counts forced releases (preemptions) for the coverage and property bench.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MAX_HOLD, 4, grant cycles after which a contended owner is preempted (>=1).
- CNT_W, 16, width of the preemption counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk.
- req  input  NREQ  level request per requester; bit i = requester i.
- done  input  NREQ  owner signals end of access; only bit [owner] is observed.
- gnt  output  NREQ  registered one-hot grant, or all zero.
- gnt_idx  output  $clog2(NREQ)  index of current owner; 0 when gnt==0.
- busy  output  1  high while in GRANT.
- nb_preempts  output  CNT_W  saturating count of forced releases.

Behaviour:
- Registers: state {IDLE, GRANT, TURN}, owner, last (round-robin pointer), hold_cnt ($clog2(MAX_HOLD+1) bits), nb_preempts.
- Reset (reset==0 at posedge):
  - state=IDLE, gnt=0, gnt_idx=0, busy=0, nb_preempts=0, hold_cnt=0.
  - last=NREQ-1, so requester 0 wins the first arbitration.
  - Reset mid-grant drops gnt at that same edge, with no turnaround.
- Arbitration function:
  - Scans req starting at (last+1) mod NREQ, with wrap-around.
  - First set bit wins.
- IDLE:
  - req!=0 sampled at edge N: gnt[winner]=1 from edge N, state=GRANT, owner=winner, last=winner, hold_cnt=0.
  - Latency req->gnt is 1 cycle.
  - req==0: stay in IDLE.
- GRANT:
  - gnt=onehot(owner), busy=1.
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - done[owner]==1: next state TURN, gnt=0. Not a preemption.
  - Else if hold_cnt==MAX_HOLD-1 and (req & ~onehot(owner))!=0: next state TURN, gnt=0, nb_preempts+=1 (saturates at all-ones).
  - Else stay in GRANT. An uncontended owner holds the grant indefinitely.
  - done and the preempt condition in the same cycle: treated as done, counter unchanged.
  - Owner dropping req without done: grant is kept. Only done or preemption releases it.
  - done bits of non-owners are ignored in every state.
- TURN (exactly one cycle, gnt=0, busy=0):
  - Arbitrates on current req.
  - req!=0: state=GRANT with the new winner, hold_cnt=0.
  - req==0: state=IDLE.
  - A preempted owner still requesting competes normally. Round-robin places it last, so it is only re-granted if it is the sole requester.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_idx is consistent with gnt.
  - No two consecutive grants to different owners without a TURN cycle between them.

Optional Feature:
- Macro: MEM_ARB_PRIO0_EN.
- Defined: requester 0 is urgent.
  - In GRANT with owner!=0 and req[0]==1 and done[owner]==0: immediate preempt to TURN regardless of hold_cnt, nb_preempts+=1.
  - In TURN and IDLE, req[0] wins over round-robin order; last is still updated to the winner.
  - Requester 0 itself is never preempted by hold_cnt.
- Not defined: pure round-robin, no urgent path; req[0] has no special handling.

Test Plan:
- Reset release, req=3'b011 at edge 1 -> gnt=3'b001, gnt_idx=0 at edge 2; done[0] at edge 4 -> gnt=0 at edge 5 (TURN); gnt=3'b010 at edge 6.
- req=3'b010 held, done never asserted, 20 cycles -> gnt=3'b010 throughout, nb_preempts=0.
- Owner 1 granted, req=3'b110 held, MAX_HOLD=4 -> gnt drops after 4 grant cycles, 1 TURN cycle, gnt=3'b100, nb_preempts=1.
- Simultaneous done[owner] and hold threshold with contention -> TURN, nb_preempts unchanged.
- reset=0 asserted during GRANT (owner 2) -> at that edge gnt=0, nb_preempts=0; with req=3'b111 after release, first gnt=3'b001.
- With MEM_ARB_PRIO0_EN: owner 2 at hold_cnt=1, req[0] rises -> next edge gnt=0 (TURN), then gnt=3'b001, nb_preempts+1.
- Without MEM_ARB_PRIO0_EN: same stimulus -> owner 2 keeps gnt until done or hold expiry.

Source files
------------

// File: rtl/mem_rr_arbiter_if.sv
// Request/grant bundle between NREQ requesters and mem_rr_arbiter.
// The requester side uses modport master; the arbiter uses modport slave.
interface mem_rr_arbiter_if #(
   parameter int NREQ  = 3,
   parameter int CNT_W = 16
);
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  done;
   logic [NREQ-1:0]  gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             busy;
   logic [CNT_W-1:0] nb_preempts;

   modport master (output req, done, input gnt, gnt_idx, busy, nb_preempts);
   modport slave  (input req, done, output gnt, gnt_idx, busy, nb_preempts);
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin owner arbiter for the shared memory port, with a turnaround cycle and hold-time preemption.
// Optional macro MEM_ARB_PRIO0_EN makes requester 0 urgent (wins arbitration, preempts any other owner).
module mem_rr_arbiter #(
   parameter int NREQ     = 3,
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 16
) (
   input  logic           clk,
   input  logic           reset,
   mem_rr_arbiter_if.slave bus
);
   localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
   localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NREQ - 1);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  preempt_q;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
   logic              busy_q;

   logic              found;
   logic [IDX_W-1:0]  win;
   logic [IDX_W-1:0]  cand;
   logic [NREQ-1:0]   owner_oh;
   logic              contended;
   logic              preempt;

   // Scan starts just after the last winner so every requester gets a turn.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDX_W'((int'(last_q) + k) % NREQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
`ifdef MEM_ARB_PRIO0_EN
      if (bus.req[0]) begin
         found = 1'b1;
         win   = '0;
      end
`endif
   end

   assign owner_oh  = NREQ'(1) << owner_q;
   assign contended = |(bus.req & ~owner_oh);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      preempt = 1'b0;

      unique case (state_q)
         IDLE, TURN: begin
            if (found) begin
               state_d = GRANT;
               owner_d = win;
               last_d  = win;
               hold_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
            // A normal done always wins over a simultaneous preemption.
            if (bus.done[owner_q]) begin
               state_d = TURN;
`ifdef MEM_ARB_PRIO0_EN
            end else if (owner_q != '0 && bus.req[0]) begin
               state_d = TURN;
               preempt = 1'b1;
            end else if (owner_q != '0 && hold_q == HOLD_LAST && contended) begin
               state_d = TURN;
               preempt = 1'b1;
`else
            end else if (hold_q == HOLD_LAST && contended) begin
               state_d = TURN;
               preempt = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      gnt_d     = (state_d == GRANT) ? (NREQ'(1) << owner_d) : '0;
      gnt_idx_d = (state_d == GRANT) ? owner_d : '0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!reset) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         last_q    <= LAST_INIT;
         hold_q    <= '0;
         preempt_q <= '0;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         busy_q    <= (state_d == GRANT);
         if (preempt && preempt_q != '1) preempt_q <= preempt_q + 1'b1;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.gnt_idx     = gnt_idx_q;
   assign bus.busy        = busy_q;
   assign bus.nb_preempts = preempt_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter (NREQ=3, MAX_HOLD=4); expectations follow MEM_ARB_PRIO0_EN when defined.
module tb_mem_rr_arbiter;
   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   mem_rr_arbiter_if #(.NREQ(3), .CNT_W(16)) bus ();

   mem_rr_arbiter #(.NREQ(3), .MAX_HOLD(4), .CNT_W(16)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b0_00_000) begin
         miscompares++;
         $display("FAIL reset_state: busy/idx/gnt=%b/%0d/%b want 0/0/000", bus.busy, bus.gnt_idx, bus.gnt);
      end
      vectors++;
      if (bus.nb_preempts !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_count: nb_preempts=%0d want 0", bus.nb_preempts);
      end
      reset = 1'b1;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b0_00_000) begin
         miscompares++;
         $display("FAIL idle_no_req: busy/idx/gnt=%b/%0d/%b want 0/0/000", bus.busy, bus.gnt_idx, bus.gnt);
      end
   endtask

   task automatic test_basic();
      bus.req = 3'b011;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_00_001) begin
         miscompares++;
         $display("FAIL basic_first_grant: busy/idx/gnt=%b/%0d/%b want 1/0/001", bus.busy, bus.gnt_idx, bus.gnt);
      end
      tick();
      vectors++;
      if (bus.gnt !== 3'b001) begin
         miscompares++;
         $display("FAIL basic_hold: gnt=%b want 001", bus.gnt);
      end
      bus.done = 3'b001;
      bus.req  = 3'b010;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b0_00_000) begin
         miscompares++;
         $display("FAIL basic_turn: busy/idx/gnt=%b/%0d/%b want 0/0/000", bus.busy, bus.gnt_idx, bus.gnt);
      end
      bus.done = 3'b000;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_01_010) begin
         miscompares++;
         $display("FAIL basic_second_grant: busy/idx/gnt=%b/%0d/%b want 1/1/010", bus.busy, bus.gnt_idx, bus.gnt);
      end
      bus.req  = 3'b000;
      bus.done = 3'b010;
      tick();
      bus.done = 3'b000;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b0_00_000) begin
         miscompares++;
         $display("FAIL basic_back_to_idle: busy/idx/gnt=%b/%0d/%b want 0/0/000", bus.busy, bus.gnt_idx, bus.gnt);
      end
   endtask

   task automatic test_uncontended();
      bus.req = 3'b010;
      tick();
      for (int i = 0; i < 20; i++) begin
         vectors++;
         if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_01_010) begin
            miscompares++;
            $display("FAIL uncontended_hold[%0d]: busy/idx/gnt=%b/%0d/%b want 1/1/010", i, bus.busy, bus.gnt_idx, bus.gnt);
         end
         tick();
      end
      vectors++;
      if (bus.nb_preempts !== 16'd0) begin
         miscompares++;
         $display("FAIL uncontended_count: nb_preempts=%0d want 0", bus.nb_preempts);
      end
      bus.done = 3'b010;
      bus.req  = 3'b000;
      tick();
      bus.done = 3'b000;
      tick();
   endtask

   task automatic test_preempt();
      bus.req = 3'b010;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_01_010) begin
         miscompares++;
         $display("FAIL preempt_grant1: busy/idx/gnt=%b/%0d/%b want 1/1/010", bus.busy, bus.gnt_idx, bus.gnt);
      end
      bus.req = 3'b110;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (bus.gnt !== 3'b010) begin
            miscompares++;
            $display("FAIL preempt_hold[%0d]: gnt=%b want 010", i, bus.gnt);
         end
      end
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b0_00_000) begin
         miscompares++;
         $display("FAIL preempt_turn: busy/idx/gnt=%b/%0d/%b want 0/0/000", bus.busy, bus.gnt_idx, bus.gnt);
      end
      vectors++;
      if (bus.nb_preempts !== 16'd1) begin
         miscompares++;
         $display("FAIL preempt_count: nb_preempts=%0d want 1", bus.nb_preempts);
      end
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_10_100) begin
         miscompares++;
         $display("FAIL preempt_next_owner: busy/idx/gnt=%b/%0d/%b want 1/2/100", bus.busy, bus.gnt_idx, bus.gnt);
      end
      bus.req  = 3'b000;
      bus.done = 3'b100;
      tick();
      bus.done = 3'b000;
      tick();
   endtask

   task automatic test_done_at_threshold();
      bus.req = 3'b001;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_00_001) begin
         miscompares++;
         $display("FAIL thr_grant0: busy/idx/gnt=%b/%0d/%b want 1/0/001", bus.busy, bus.gnt_idx, bus.gnt);
      end
      bus.req = 3'b011;
      repeat (3) tick();
      vectors++;
      if (bus.gnt !== 3'b001) begin
         miscompares++;
         $display("FAIL thr_before_limit: gnt=%b want 001", bus.gnt);
      end
      bus.done = 3'b001;
      bus.req  = 3'b010;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt} !== 4'b0_000) begin
         miscompares++;
         $display("FAIL thr_done_turn: busy/gnt=%b/%b want 0/000", bus.busy, bus.gnt);
      end
      vectors++;
      if (bus.nb_preempts !== 16'd1) begin
         miscompares++;
         $display("FAIL thr_count_unchanged: nb_preempts=%0d want 1", bus.nb_preempts);
      end
      bus.done = 3'b000;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_01_010) begin
         miscompares++;
         $display("FAIL thr_next_owner: busy/idx/gnt=%b/%0d/%b want 1/1/010", bus.busy, bus.gnt_idx, bus.gnt);
      end
      bus.done = 3'b101;
      tick();
      vectors++;
      if (bus.gnt !== 3'b010) begin
         miscompares++;
         $display("FAIL non_owner_done: gnt=%b want 010", bus.gnt);
      end
      bus.done = 3'b000;
      bus.req  = 3'b000;
      repeat (2) tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_01_010) begin
         miscompares++;
         $display("FAIL owner_drops_req: busy/idx/gnt=%b/%0d/%b want 1/1/010", bus.busy, bus.gnt_idx, bus.gnt);
      end
      bus.done = 3'b010;
      tick();
      bus.done = 3'b000;
      bus.req  = 3'b100;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_10_100) begin
         miscompares++;
         $display("FAIL thr_grant2: busy/idx/gnt=%b/%0d/%b want 1/2/100", bus.busy, bus.gnt_idx, bus.gnt);
      end
   endtask

   task automatic test_reset_mid_grant();
      reset = 1'b0;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b0_00_000) begin
         miscompares++;
         $display("FAIL midreset_drop: busy/idx/gnt=%b/%0d/%b want 0/0/000", bus.busy, bus.gnt_idx, bus.gnt);
      end
      vectors++;
      if (bus.nb_preempts !== 16'd0) begin
         miscompares++;
         $display("FAIL midreset_count: nb_preempts=%0d want 0", bus.nb_preempts);
      end
      reset   = 1'b1;
      bus.req = 3'b111;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_00_001) begin
         miscompares++;
         $display("FAIL midreset_first_grant: busy/idx/gnt=%b/%0d/%b want 1/0/001", bus.busy, bus.gnt_idx, bus.gnt);
      end
   endtask

   task automatic test_prio0();
      bus.done = 3'b001;
      bus.req  = 3'b100;
      tick();
      bus.done = 3'b000;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_10_100) begin
         miscompares++;
         $display("FAIL prio_owner2: busy/idx/gnt=%b/%0d/%b want 1/2/100", bus.busy, bus.gnt_idx, bus.gnt);
      end
      tick();
      bus.req = 3'b101;
`ifdef MEM_ARB_PRIO0_EN
      tick();
      vectors++;
      if ({bus.busy, bus.gnt} !== 4'b0_000) begin
         miscompares++;
         $display("FAIL prio_urgent_turn: busy/gnt=%b/%b want 0/000", bus.busy, bus.gnt);
      end
`else
      repeat (2) begin
         tick();
         vectors++;
         if (bus.gnt !== 3'b100) begin
            miscompares++;
            $display("FAIL prio_off_keep: gnt=%b want 100", bus.gnt);
         end
      end
      tick();
      vectors++;
      if ({bus.busy, bus.gnt} !== 4'b0_000) begin
         miscompares++;
         $display("FAIL prio_off_hold_expiry: busy/gnt=%b/%b want 0/000", bus.busy, bus.gnt);
      end
`endif
      vectors++;
      if (bus.nb_preempts !== 16'd1) begin
         miscompares++;
         $display("FAIL prio_count: nb_preempts=%0d want 1", bus.nb_preempts);
      end
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b1_00_001) begin
         miscompares++;
         $display("FAIL prio_grant0: busy/idx/gnt=%b/%0d/%b want 1/0/001", bus.busy, bus.gnt_idx, bus.gnt);
      end
      bus.req  = 3'b000;
      bus.done = 3'b001;
      tick();
      bus.done = 3'b000;
      tick();
      vectors++;
      if ({bus.busy, bus.gnt_idx, bus.gnt} !== 6'b0_00_000) begin
         miscompares++;
         $display("FAIL prio_final_idle: busy/idx/gnt=%b/%0d/%b want 0/0/000", bus.busy, bus.gnt_idx, bus.gnt);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      bus.req     = '0;
      bus.done    = '0;
      repeat (2) tick();
      test_reset();
      test_basic();
      test_uncontended();
      test_preempt();
      test_done_at_threshold();
      test_reset_mid_grant();
      test_prio0();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
